// File: rtl/sdp_bram_pkg.sv
// Shared constants and elaboration helpers for the simple dual-port block RAM.
package sdp_bram_pkg;

  // Read-during-write behaviour for a same-address read and write on one edge
  localparam int RDW_OLD = 0;  // read returns the word as it was before the write
  localparam int RDW_NEW = 1;  // read returns the merged, freshly written word

  // Number of write-enable lanes in a word
  function automatic int nbytes(input int dw, input int bw);
    return dw / bw;
  endfunction

  // Parameter sanity check evaluated at elaboration by the top level
  function automatic bit params_ok(input int aw, input int dw, input int bw,
                                   input int out_reg, input int rdw_mode);
    return (aw > 0) && (bw > 0) && (dw >= bw) && ((dw % bw) == 0) &&
           ((out_reg == 0) || (out_reg == 1)) &&
           ((rdw_mode == RDW_OLD) || (rdw_mode == RDW_NEW));
  endfunction

endpackage

// File: rtl/sdp_bram_core.sv
// Plain inferable simple dual-port RAM: unreset array, byte-lane writes,
// registered old-data read. Only the read register is cleared by reset.
module sdp_bram_core
  import sdp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  localparam int NUM_BYTES = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Byte-lane write; lanes with a cleared enable keep their stored value
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered read; holds the last word when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sdp_bram_pipelined.sv
// Simple dual-port block RAM with byte enables, read-valid tracking,
// optional output register and selectable read-during-write behaviour.
module sdp_bram_pipelined
  import sdp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 1,
  parameter int RDW_MODE   = 0,
  localparam int NUM_BYTES = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  generate
    if (!params_ok(ADDR_WIDTH, DATA_WIDTH, BYTE_WIDTH, OUT_REG, RDW_MODE)) begin : g_param_check
      $error("sdp_bram_pipelined: illegal parameter combination");
    end
  endgenerate

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] core_rd_data;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  v1_reg;

  // Writes are blocked while reset is held so memory contents stay intact
  assign wr_en = we & rst_n;

  sdp_bram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_be   (be),
    .wr_addr (addr_w),
    .wr_data (din),
    .rd_en   (re),
    .rd_addr (addr_r),
    .rd_data (core_rd_data)
  );

  // Stage-1 valid: one flag per read issued on the previous edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= re;
    end
  end

  generate
    if (RDW_MODE == RDW_NEW) begin : g_rdw_new
      logic                  fwd_hit_reg;
      logic [NUM_BYTES-1:0]  fwd_be_reg;
      logic [DATA_WIDTH-1:0] fwd_din_reg;

      // Snapshot the colliding write alongside each read so the merge stays
      // stable while stage 1 holds its value between reads
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fwd_hit_reg <= 1'b0;
          fwd_be_reg  <= '0;
          fwd_din_reg <= '0;
        end else if (re) begin
          fwd_hit_reg <= we && (addr_w == addr_r);
          fwd_be_reg  <= be;
          fwd_din_reg <= din;
        end
      end

      // Per-lane merge: freshly written lanes replace the old-data read
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH] =
          (fwd_hit_reg && fwd_be_reg[gi]) ? fwd_din_reg[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                          : core_rd_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end else begin : g_rdw_old
      assign s1_data = core_rd_data;
    end
  endgenerate

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_reg;
      logic                  v2_reg;

      // Extra output register; stage 1 holds between reads, so dout holds too
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_reg <= '0;
          v2_reg      <= 1'b0;
        end else begin
          s2_data_reg <= s1_data;
          v2_reg      <= v1_reg;
        end
      end

      assign dout       = s2_data_reg;
      assign dout_valid = v2_reg;
    end else begin : g_no_out_reg
      assign dout       = s1_data;
      assign dout_valid = v1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_bram_pipelined.sv
// Directed bench: two instances share stimulus.
//   u_a: OUT_REG=1, RDW_MODE=0 (latency 2, old data on collision)
//   u_b: OUT_REG=0, RDW_MODE=1 (latency 1, forwarded data on collision)
module tb_sdp_bram_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [9:0]  addr_w = '0;
  logic [31:0] din = '0;
  logic        re = 1'b0;
  logic [9:0]  addr_r = '0;
  logic [31:0] dout_a, dout_b;
  logic        valid_a, valid_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdp_bram_pipelined #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_w(addr_w), .din(din),
    .re(re), .addr_r(addr_r), .dout(dout_a), .dout_valid(valid_a)
  );

  sdp_bram_pipelined #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_w(addr_w), .din(din),
    .re(re), .addr_r(addr_r), .dout(dout_b), .dout_valid(valid_b)
  );

  typedef struct {
    logic [9:0]  aw;
    logic [3:0]  be;
    logic [31:0] din;
    logic [9:0]  ar;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
    we = 1'b1; be = b; addr_w = a; din = d;
    cyc();
    we = 1'b0; be = 4'h0;
  endtask

  // One read; checks b at latency 1, a at latency 2, and single-cycle valid pulses
  task automatic rd_chk(input logic [9:0] a, input logic [31:0] exp, input string name);
    re = 1'b1; addr_r = a;
    cyc();
    re = 1'b0;
    chk({name, " b.valid"}, {31'b0, valid_b}, 32'd1);
    chk({name, " b.dout"}, dout_b, exp);
    chk({name, " a.valid@1"}, {31'b0, valid_a}, 32'd0);
    cyc();
    chk({name, " b.valid@2"}, {31'b0, valid_b}, 32'd0);
    chk({name, " b.hold"}, dout_b, exp);
    chk({name, " a.valid"}, {31'b0, valid_a}, 32'd1);
    chk({name, " a.dout"}, dout_a, exp);
    cyc();
    chk({name, " a.valid@3"}, {31'b0, valid_a}, 32'd0);
    chk({name, " a.hold"}, dout_a, exp);
  endtask

  initial begin
    tbl[0] = '{aw:10'h005, be:4'hF, din:32'hAABBCCDD, ar:10'h005, exp:32'hAABBCCDD};
    tbl[1] = '{aw:10'h005, be:4'h5, din:32'h11223344, ar:10'h005, exp:32'hAA22CC44};
    tbl[2] = '{aw:10'h3FF, be:4'hF, din:32'hDEADBEEF, ar:10'h3FF, exp:32'hDEADBEEF};
    tbl[3] = '{aw:10'h000, be:4'hF, din:32'h01234567, ar:10'h000, exp:32'h01234567};
    tbl[4] = '{aw:10'h3FF, be:4'h8, din:32'h00000000, ar:10'h3FF, exp:32'h00ADBEEF};
    tbl[5] = '{aw:10'h000, be:4'h0, din:32'hFFFFFFFF, ar:10'h000, exp:32'h01234567};
    tbl[6] = '{aw:10'h005, be:4'hA, din:32'h99887766, ar:10'h005, exp:32'h99227744};

    // T1a: outputs held at zero while reset is asserted with requests active
    we = 1'b1; be = 4'hF; addr_w = 10'd9; din = 32'h12345678; re = 1'b1; addr_r = 10'd9;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst0 a.dout", dout_a, 32'h0);
      chk("rst0 b.dout", dout_b, 32'h0);
      chk("rst0 a.valid", {31'b0, valid_a}, 32'd0);
      chk("rst0 b.valid", {31'b0, valid_b}, 32'd0);
    end
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;
    cyc();

    // T1b: contents survive reset; writes during reset are ignored
    wr(10'd9, 4'hF, 32'h5555AAAA);
    cyc();
    rst_n = 1'b0;
    we = 1'b1; be = 4'hF; addr_w = 10'd9; din = 32'hFFFFFFFF; re = 1'b1; addr_r = 10'd9;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst1 a.dout", dout_a, 32'h0);
      chk("rst1 b.dout", dout_b, 32'h0);
      chk("rst1 a.valid", {31'b0, valid_a}, 32'd0);
      chk("rst1 b.valid", {31'b0, valid_b}, 32'd0);
    end
    we = 1'b0; be = 4'h0; re = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("rst1 post a.valid", {31'b0, valid_a}, 32'd0);
    chk("rst1 post b.valid", {31'b0, valid_b}, 32'd0);
    rd_chk(10'd9, 32'h5555AAAA, "rst_survive");

    // Table: write, idle, read back (T2 byte enables, boundary, be=0 no-op)
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].aw, tbl[i].be, tbl[i].din);
      cyc();
      rd_chk(tbl[i].ar, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // T3: streaming reads, one result per cycle for both latencies
    for (int k = 0; k < 16; k++) wr(10'(k), 4'hF, 32'(k));
    for (int k = 0; k < 18; k++) begin
      re = (k < 16); addr_r = 10'(k);
      cyc();
      chk($sformatf("stream%0d b.valid", k), {31'b0, valid_b}, (k < 16) ? 32'd1 : 32'd0);
      if (k < 16) chk($sformatf("stream%0d b.dout", k), dout_b, 32'(k));
      chk($sformatf("stream%0d a.valid", k), {31'b0, valid_a},
          (k >= 1 && k <= 16) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 16) chk($sformatf("stream%0d a.dout", k), dout_a, 32'(k - 1));
    end
    re = 1'b0;
    cyc();

    // T4: same-address read during partial write
    wr(10'd7, 4'hF, 32'h0);
    we = 1'b1; be = 4'h3; din = 32'hFFFFFFFF; addr_w = 10'd7; re = 1'b1; addr_r = 10'd7;
    cyc();
    we = 1'b0; be = 4'h0; re = 1'b0;
    chk("rdw b.valid", {31'b0, valid_b}, 32'd1);
    chk("rdw b.dout(new)", dout_b, 32'h0000FFFF);
    cyc();
    chk("rdw a.valid", {31'b0, valid_a}, 32'd1);
    chk("rdw a.dout(old)", dout_a, 32'h00000000);
    cyc();
    rd_chk(10'd7, 32'h0000FFFF, "rdw_after");

    // Different-address read and write in the same cycle are independent
    we = 1'b1; be = 4'hF; din = 32'h12345678; addr_w = 10'd8; re = 1'b1; addr_r = 10'd7;
    cyc();
    we = 1'b0; be = 4'h0; re = 1'b0;
    chk("diff b.dout", dout_b, 32'h0000FFFF);
    cyc();
    chk("diff a.dout", dout_a, 32'h0000FFFF);
    cyc();
    rd_chk(10'd8, 32'h12345678, "diff_wr");

    // T5: top and bottom addresses written on consecutive cycles
    we = 1'b1; be = 4'hF; addr_w = 10'h3FF; din = 32'hCAFEF00D;
    cyc();
    addr_w = 10'h000; din = 32'h0BADC0DE;
    cyc();
    we = 1'b0; be = 4'h0;
    rd_chk(10'h3FF, 32'hCAFEF00D, "bound_top");
    rd_chk(10'h000, 32'h0BADC0DE, "bound_bot");

    // T6: reset lands while a read is in flight
    wr(10'd20, 4'hF, 32'h20202020);
    re = 1'b1; addr_r = 10'd20;
    cyc();
    re = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst a.valid", {31'b0, valid_a}, 32'd0);
    chk("midrst b.valid", {31'b0, valid_b}, 32'd0);
    chk("midrst b.dout", dout_b, 32'h0);
    cyc();
    chk("midrst2 a.valid", {31'b0, valid_a}, 32'd0);
    chk("midrst2 a.dout", dout_a, 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("midrst post a.valid", {31'b0, valid_a}, 32'd0);
      chk("midrst post b.valid", {31'b0, valid_b}, 32'd0);
    end
    rd_chk(10'd20, 32'h20202020, "midrst_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
